// File: rtl/cfg_loader_pkg.sv
// ============================================================================
// Module      : cfg_loader_pkg
// Description : Shared types and helpers for the configuration scan-chain
//               loader: FSM state encoding and a word-count helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cfg_loader_pkg;

    // Loader FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of configuration words needed to fill a chain of chain_len bits
    // with words of word_w bits (the last word may be only partly shifted).
    function automatic int words_needed(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

endpackage : cfg_loader_pkg

`default_nettype wire

// File: rtl/cfg_piso.sv
// ============================================================================
// Module      : cfg_piso
// Description : WORD_W-bit parallel-in / serial-out hold register, MSB first.
//               Tracks how many bits of the held word remain to be shifted.
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               load, load_data - capture a new word, bits_left = WORD_W
//               shift           - shift left by one when bits remain
//               flush           - discard the held word (highest priority)
//               msb             - bit currently presented to the chain
//               bits_left       - bits of the held word not yet shifted
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cfg_piso #(
    parameter int WORD_W = 8,
    parameter int BL_W   = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic              flush,
    input  logic [WORD_W-1:0] load_data,
    output logic              msb,
    output logic [BL_W-1:0]   bits_left
);

    localparam logic [BL_W-1:0] c_full = BL_W'(WORD_W);
    localparam logic [BL_W-1:0] c_one  = BL_W'(1);

    logic [WORD_W-1:0] r_hold;
    logic [BL_W-1:0]   r_bits_left;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold      <= '0;
            r_bits_left <= '0;
        end else if (flush) begin
            r_hold      <= '0;
            r_bits_left <= '0;
        end else if (load) begin
            r_hold      <= load_data;
            r_bits_left <= c_full;
        end else if (shift && (r_bits_left != '0)) begin
            r_hold      <= r_hold << 1;
            r_bits_left <= r_bits_left - c_one;
        end
    end

    assign msb       = r_hold[WORD_W-1];
    assign bits_left = r_bits_left;

endmodule : cfg_piso

`default_nettype wire

// File: rtl/cfg_chain_loader.sv
// ============================================================================
// Module      : cfg_chain_loader
// Description : Feeds the interconnect configuration scan chain. Accepts
//               words over valid/ready, shifts them MSB-first onto the chain
//               for exactly CHAIN_LEN bits, then releases config-enable.
// Ports       : clk, rst  - clock, asynchronous active-high reset
//               start     - begin a load (IDLE only)
//               abort     - cancel a load in progress
//               in_data / in_valid / in_ready - configuration word stream
//               cfg_en    - chain config_en, high for the whole load
//               cfg_shift - chain shift enable, one bit per cycle
//               cfg_data  - chain serial input
//               busy      - load in progress
//               done      - one-cycle pulse on successful completion
//               err       - sticky abort flag, cleared by accepted start
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cfg_chain_loader
    import cfg_loader_pkg::*;
#(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 48,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              cfg_en,
    output logic              cfg_shift,
    output logic              cfg_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int               c_bl_w = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_shifted;
    logic              r_err;
    logic [c_bl_w-1:0] w_bits_left;
    logic              w_msb;
    logic              w_empty;
    logic              w_begin;
    logic              w_last_shift;
    logic              w_piso_load;
    logic              w_piso_flush;

    assign w_empty      = (w_bits_left == '0);
    assign w_begin      = (r_state == ST_IDLE) && start;
    // The terminal test uses the count before this shift, so the counter
    // tops out at CHAIN_LEN and never wraps.
    assign w_last_shift = cfg_shift && (r_shifted == c_last);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        cfg_en      = 1'b0;
        cfg_shift   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cfg_en    = 1'b1;
                busy      = 1'b1;
                in_ready  = w_empty;
                cfg_shift = !w_empty;
                // Abort takes precedence over the final shift.
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (!w_empty && (r_shifted == c_last)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign cfg_data = cfg_shift & w_msb;

    // ------------------------------------------------------------------
    // Hold register control. The word is flushed on abort and on the
    // final shift, so leftover low bits of a truncated word are dropped.
    // ------------------------------------------------------------------
    assign w_piso_load  = in_valid && in_ready && !abort;
    assign w_piso_flush = w_begin || (busy && abort) || w_last_shift;

    cfg_piso #(
        .WORD_W (WORD_W),
        .BL_W   (c_bl_w)
    ) u_piso (
        .clk       (clk),
        .rst       (rst),
        .load      (w_piso_load),
        .shift     (cfg_shift),
        .flush     (w_piso_flush),
        .load_data (in_data),
        .msb       (w_msb),
        .bits_left (w_bits_left)
    );

    // ------------------------------------------------------------------
    // Shifted-bit counter and sticky error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shifted <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_begin) begin
                r_shifted <= '0;
            end else if (cfg_shift && !abort) begin
                r_shifted <= r_shifted + c_one;
            end

            if (w_begin) begin
                r_err <= 1'b0;
            end else if (busy && abort) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;

endmodule : cfg_chain_loader

`default_nettype wire

// File: tb/tb_cfg_chain_loader.sv
// ============================================================================
// Module      : tb_cfg_chain_loader
// Description : Self-checking bench for cfg_chain_loader. Two instances:
//               A (WORD_W=8, CHAIN_LEN=48) and B (WORD_W=8, CHAIN_LEN=12).
//               Expected serial streams come from a bit-queue model of the
//               words presented; chain contents from a downstream chain model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cfg_chain_loader;
    import cfg_loader_pkg::*;

    localparam int W   = 8;
    localparam int CLA = 48;
    localparam int CLB = 12;

    logic clk = 1'b0;
    logic rst;
    logic start_a, start_b, abort, in_valid;
    logic [W-1:0] in_data;
    logic ready_a, en_a, sh_a, dat_a, busy_a, done_a, err_a;
    logic ready_b, en_b, sh_b, dat_b, busy_b, done_b, err_b;

    cfg_chain_loader #(.WORD_W(W), .CHAIN_LEN(CLA)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(ready_a),
        .cfg_en(en_a), .cfg_shift(sh_a), .cfg_data(dat_a),
        .busy(busy_a), .done(done_a), .err(err_a)
    );

    cfg_chain_loader #(.WORD_W(W), .CHAIN_LEN(CLB)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(ready_b),
        .cfg_en(en_b), .cfg_shift(sh_b), .cfg_data(dat_b),
        .busy(busy_b), .done(done_b), .err(err_b)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Monitors: downstream chain models, shift/done counters, invariants
    // ------------------------------------------------------------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit          obs_a[$];
    bit          obs_b[$];
    logic [47:0] chain_a = '0;
    logic [11:0] chain_b = '0;
    int shifts_a = 0, shifts_b = 0, dones_a = 0, dones_b = 0;
    int viol_a = 0, viol_b = 0, dcyc_a = 0, dcyc_b = 0;

    always @(negedge clk) begin
        if (sh_a) begin
            obs_a.push_back(dat_a);
            chain_a  <= {chain_a[46:0], dat_a};
            shifts_a <= shifts_a + 1;
        end
        if (done_a) begin
            dones_a <= dones_a + 1;
            dcyc_a  <= cyc;
        end
        if ((ready_a && !busy_a) || (sh_a && !busy_a) || (ready_a && sh_a) ||
            (en_a != busy_a) || (!sh_a && dat_a) || (done_a && busy_a))
            viol_a <= viol_a + 1;
    end

    always @(negedge clk) begin
        if (sh_b) begin
            obs_b.push_back(dat_b);
            chain_b  <= {chain_b[10:0], dat_b};
            shifts_b <= shifts_b + 1;
        end
        if (done_b) begin
            dones_b <= dones_b + 1;
            dcyc_b  <= cyc;
        end
        if ((ready_b && !busy_b) || (sh_b && !busy_b) || (ready_b && sh_b) ||
            (en_b != busy_b) || (!sh_b && dat_b) || (done_b && busy_b))
            viol_b <= viol_b + 1;
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check48(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %012h expected %012h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Vector record: stimulus controls and expected outcome
    // ------------------------------------------------------------------
    typedef struct {
        bit                 sel;          // 0: instance A, 1: instance B
        logic [0:5][W-1:0]  w;            // words, w[0] sent first
        int                 n;
        int                 vprob;        // percent chance in_valid is high
        int                 abort_k;      // abort when this many bits shifted (-1: never)
        bit                 abort_on_shift;
        bit                 restart;      // pulse start mid-load
        bit                 start_abort;  // abort together with start
        int                 exp_shifts;
        bit                 exp_done;
        bit                 exp_err;
        bit                 chk_chain;
        logic [47:0]        exp_chain;
        int                 exp_lat;      // done cycle minus first handshake (-1: skip)
    } vec_t;

    function automatic vec_t mk(input bit sel, input logic [0:5][W-1:0] w, input int n,
                                input int vprob, input int abort_k, input bit aos,
                                input bit restart, input bit sa, input int exp_shifts,
                                input bit exp_done, input bit exp_err, input bit chk,
                                input logic [47:0] exp_chain, input int exp_lat);
        vec_t v;
        v.sel = sel; v.w = w; v.n = n; v.vprob = vprob; v.abort_k = abort_k;
        v.abort_on_shift = aos; v.restart = restart; v.start_abort = sa;
        v.exp_shifts = exp_shifts; v.exp_done = exp_done; v.exp_err = exp_err;
        v.chk_chain = chk; v.exp_chain = exp_chain; v.exp_lat = exp_lat;
        return v;
    endfunction

    // Reference: the words as one MSB-first bit stream, cut at the chain length.
    function automatic logic [47:0] model_chain(input vec_t v, input int cl);
        logic [47:0] c = '0;
        int k = 0;
        for (int i = 0; i < v.n; i++)
            for (int b = W - 1; b >= 0; b--)
                if (k < cl) begin
                    c = {c[46:0], v.w[i][b]};
                    k++;
                end
        return c;
    endfunction

    // ------------------------------------------------------------------
    // Run one load and check it
    // ------------------------------------------------------------------
    task automatic run_vec(input string id, input vec_t v);
        int idx = 0, guard = 0, hs_first = -1, extra = 0, mism = 0;
        int sh0, dn0, vi0, ob0;
        bit abort_done = 0, rs_done = 0, timed_out = 0;
        bit rdy, bsy, x_en, x_done, x_err, x_rdy, en_pre;
        bit exp_bits[$];

        for (int i = 0; i < v.n; i++)
            for (int b = W - 1; b >= 0; b--)
                exp_bits.push_back(v.w[i][b]);

        sh0 = v.sel ? shifts_b : shifts_a;
        dn0 = v.sel ? dones_b  : dones_a;
        vi0 = v.sel ? viol_b   : viol_a;
        ob0 = v.sel ? obs_b.size() : obs_a.size();

        // Start cycle; in_valid is high but must be ignored in IDLE.
        if (v.sel) start_b = 1'b1; else start_a = 1'b1;
        abort    = v.start_abort;
        in_valid = 1'b1;
        in_data  = W'($urandom);
        @(negedge clk);
        en_pre = v.sel ? en_b : en_a;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        abort   = 1'b0;
        check({id, "_en_before_load"}, int'(en_pre), 0);

        forever begin
            abort = 1'b0;
            if (!abort_done && v.abort_k >= 0 &&
                ((v.sel ? shifts_b : shifts_a) - sh0) == v.abort_k &&
                (!v.abort_on_shift || (v.sel ? sh_b : sh_a))) begin
                abort      = 1'b1;
                abort_done = 1;
            end
            if (v.restart && !rs_done && idx == 2) begin
                if (v.sel) start_b = 1'b1; else start_a = 1'b1;
                rs_done = 1;
            end else begin
                start_a = 1'b0;
                start_b = 1'b0;
            end
            if (idx < v.n) begin
                in_valid = ($urandom_range(99) < v.vprob);
                in_data  = in_valid ? v.w[idx] : W'($urandom);
            end else begin
                in_valid = 1'b1;           // nothing more should be accepted
                in_data  = W'($urandom);
            end
            @(negedge clk);
            rdy = v.sel ? ready_b : ready_a;
            bsy = v.sel ? busy_b  : busy_a;
            if (in_valid && rdy && !abort) begin
                if (idx == 0) hs_first = cyc;
                if (idx < v.n) idx++; else extra++;
            end
            if (!bsy) break;
            guard++;
            if (guard > 1000) begin
                timed_out = 1;
                break;
            end
            tick();
        end
        check({id, "_timeout"}, int'(timed_out), 0);

        x_en   = v.sel ? en_b    : en_a;
        x_done = v.sel ? done_b  : done_a;
        x_err  = v.sel ? err_b   : err_a;
        x_rdy  = v.sel ? ready_b : ready_a;
        in_valid = 1'b0;
        abort    = 1'b0;
        start_a  = 1'b0;
        start_b  = 1'b0;
        tick();

        check({id, "_exit_en"},    int'(x_en),   0);
        check({id, "_exit_ready"}, int'(x_rdy),  0);
        check({id, "_exit_done"},  int'(x_done), int'(v.exp_done));
        check({id, "_err"},        int'(x_err),  int'(v.exp_err));
        check({id, "_shifts"}, (v.sel ? shifts_b : shifts_a) - sh0, v.exp_shifts);
        check({id, "_done_count"}, (v.sel ? dones_b : dones_a) - dn0, v.exp_done ? 1 : 0);
        check({id, "_extra_words"}, extra, 0);
        check({id, "_invariants"}, (v.sel ? viol_b : viol_a) - vi0, 0);

        for (int i = 0; i < v.exp_shifts; i++) begin
            if (v.sel) begin
                if (ob0 + i >= obs_b.size() || obs_b[ob0 + i] != exp_bits[i]) mism++;
            end else begin
                if (ob0 + i >= obs_a.size() || obs_a[ob0 + i] != exp_bits[i]) mism++;
            end
        end
        check({id, "_stream_bit_errors"}, mism, 0);

        if (v.chk_chain)
            check48({id, "_chain"}, v.sel ? 48'(chain_b) : chain_a, v.exp_chain);
        if (v.exp_lat >= 0)
            check({id, "_done_latency"}, (v.sel ? dcyc_b : dcyc_a) - hs_first, v.exp_lat);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    vec_t vecs[6];

    initial begin
        vec_t rv;
        int   s0, guard;
        bit   shifting;

        vecs[0] = mk(0, {8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h7E}, 6, 100, -1, 0, 0, 0,
                     48, 1, 0, 1, 48'hA53CFF00817E, 54);
        vecs[1] = mk(1, {8'hF0, 8'hAB, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 100, -1, 0, 0, 0,
                     12, 1, 0, 1, 48'h000000000F0A, 14);
        vecs[2] = mk(0, {8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 100, 16, 0, 0, 0,
                     16, 0, 1, 0, 48'h0, -1);
        vecs[3] = mk(1, {8'hF0, 8'hAB, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 100, 11, 1, 0, 0,
                     12, 0, 1, 0, 48'h0, -1);
        vecs[4] = mk(0, {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66}, 6, 60, -1, 0, 0, 1,
                     48, 1, 0, 1, 48'h112233445566, -1);
        vecs[5] = mk(0, {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23}, 6, 100, -1, 0, 1, 0,
                     48, 1, 0, 1, 48'hDEADBEEF0123, 54);

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
        in_valid = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs_a", int'({ready_a, en_a, sh_a, dat_a, busy_a, done_a, err_a}), 0);
        check("reset_outputs_b", int'({ready_b, en_b, sh_b, dat_b, busy_b, done_b, err_b}), 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++)
            run_vec($sformatf("vec%0d", i), vecs[i]);

        // abort in IDLE leaves err untouched on both instances
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("idle_abort_err_a", int'(err_a), 0);
        check("idle_abort_busy_a", int'(busy_a), 0);
        check("idle_abort_err_b", int'(err_b), 1);
        tick();

        // randomized loads against the bit-stream model
        for (int i = 0; i < 8; i++) begin
            rv.sel = i[0];
            rv.n   = words_needed(rv.sel ? CLB : CLA, W);
            for (int k = 0; k < 6; k++) rv.w[k] = W'($urandom);
            rv.vprob = 20 + $urandom_range(80);
            rv.abort_k = -1; rv.abort_on_shift = 0; rv.restart = 0; rv.start_abort = 0;
            rv.exp_shifts = rv.sel ? CLB : CLA;
            rv.exp_done = 1; rv.exp_err = 0; rv.chk_chain = 1;
            rv.exp_chain = model_chain(rv, rv.exp_shifts);
            rv.exp_lat = -1;
            run_vec($sformatf("rand%0d", i), rv);
        end

        // reset during the 3rd bit of word 4 on instance A
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        s0 = shifts_a;
        guard = 0;
        while ((shifts_a - s0) != 26 && guard < 200) begin
            tick();
            guard++;
        end
        check("rst_reach_bit27", shifts_a - s0, 26);
        shifting = sh_a;
        check("rst_mid_shift", int'(shifting), 1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_outputs_a",
              int'({ready_a, en_a, sh_a, dat_a, busy_a, done_a, err_a}), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        s0 = shifts_a;
        repeat (5) begin
            tick();
            in_data = W'($urandom);
        end
        @(negedge clk);
        check("post_rst_idle_busy", int'(busy_a), 0);
        check("post_rst_idle_ready", int'(ready_a), 0);
        check("post_rst_no_shift", shifts_a - s0, 0);
        in_valid = 1'b0;
        tick();
        for (int k = 0; k < 6; k++) rv.w[k] = W'($urandom);
        rv.sel = 0; rv.n = 6; rv.vprob = 70; rv.abort_k = -1; rv.abort_on_shift = 0;
        rv.restart = 0; rv.start_abort = 0; rv.exp_shifts = CLA; rv.exp_done = 1;
        rv.exp_err = 0; rv.chk_chain = 1; rv.exp_chain = model_chain(rv, CLA); rv.exp_lat = -1;
        run_vec("post_rst_load", rv);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule : tb_cfg_chain_loader

`default_nettype wire

// File: doc/cfg_chain_loader.md
Name: cfg_chain_loader

Overview:
- Upstream feeder for the logic-element interconnect configuration scan chain.
- Accepts configuration words over a valid/ready stream and serialises them MSB-first onto the chain's serial input.
- Drives the chain's shift enable and config-enable for exactly CHAIN_LEN bit shifts, then releases config-enable so interconnect outputs become live.
- Reports done/error status to the fabric configuration controller.

Parameters:
- WORD_W, 8, width of incoming configuration words.
- CHAIN_LEN, 48, total scan-chain length in bits. Default is 4 LE inputs x 4 groups x 3 select bits for a single interconnect. Must be >= 1.
- CNT_W, $clog2(CHAIN_LEN+1), width of the shifted-bit counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a load; ignored unless in IDLE
- abort  in  1  cancels an in-progress load
- in_data  in  WORD_W  configuration word; bit WORD_W-1 is shifted first
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts in_data this cycle
- cfg_en  out  1  to chain config_en; high for the whole load
- cfg_shift  out  1  to chain en; high on each cycle a bit is shifted
- cfg_data  out  1  to chain config_data_in
- busy  out  1  high in LOAD
- done  out  1  one-cycle pulse on successful completion
- err  out  1  sticky; set by abort, cleared by the next accepted start

Behaviour:
- Reset values: all outputs 0; state IDLE; hold register, bit-in-word counter and shifted-bit counter cleared. Reset mid-load drops cfg_en immediately (asynchronously); chain contents are left as shifted.
- States: IDLE, LOAD, DONE.
- IDLE:
  - in_ready=0; in_valid is ignored.
  - start=1 -> LOAD next cycle; clears err, shifted counter and word counters.
- LOAD:
  - cfg_en=1, busy=1.
  - in_ready=1 only when the hold register is empty (bits_left==0).
  - Handshake (in_valid & in_ready) in cycle t loads the hold register and sets bits_left=WORD_W.
  - Cycles t+1..t+WORD_W: cfg_shift=1, cfg_data=hold[WORD_W-1]. On each edge the hold register shifts left by one, bits_left decrements and shifted increments.
  - in_ready reasserts in the cycle after the last shift, so throughput is one word per WORD_W+1 cycles.
  - When shifted reaches CHAIN_LEN, shifting stops at once even if bits_left>0: the remaining low bits of the last word are discarded, bits_left is forced to 0, and the state goes to DONE.
  - When cfg_shift=0, cfg_data=0.
  - The chain's first-shifted bit therefore ends at its deepest position (index CHAIN_LEN-1).
- DONE:
  - Lasts one cycle: cfg_en=0, done=1, in_ready=0. Then IDLE.
- Abort:
  - abort=1 in LOAD -> IDLE next cycle, err=1, cfg_en=0, done not pulsed. Any partial word is discarded.
  - abort in IDLE or DONE has no effect.
  - If abort arrives in the same cycle as the shift that completes CHAIN_LEN, abort wins: err=1, no done.
- Simultaneous start and abort in IDLE: start wins and err is cleared.
- start while busy: ignored.
- in_valid held with no handshake: in_data is not sampled.
- Counter widths: shifted uses CNT_W bits; bits_left uses $clog2(WORD_W+1) bits. Neither counter wraps, because the terminal comparison precedes the increment.

Decomposition:
- Package cfg_loader_pkg:
  - state enum (IDLE, LOAD, DONE)
  - helper function words_needed(CHAIN_LEN, WORD_W) = ceil(CHAIN_LEN/WORD_W), used by the bench and by fabric-level loaders.
- One natural sub-module, cfg_piso: the WORD_W parallel-in/serial-out hold register with load, shift and flush controls and a bits_left counter. The top module holds the FSM and the shifted-bit counter.

Test Plan:
- Default parameters; start, then 6 words 0xA5,0x3C,0xFF,0x00,0x81,0x7E, each with in_valid held high:
  - 48 cfg_shift pulses; serial stream 10100101 00111100 ...
  - cfg_en high from the cycle after start until DONE.
  - done pulses once, 54 cycles after the first handshake.
  - A 48-bit shift-register model matches 0xA53CFF00817E.
- CHAIN_LEN=12, WORD_W=8; words 0xF0, 0xAB:
  - 12 shifts; stream 11110000 1010; low bits 1011 of 0xAB are discarded.
  - in_ready stays 0 after the last shift; done is asserted.
- Abort after 2 words:
  - Next cycle cfg_en=0, busy=0, err=1, no done.
  - A following start clears err, and a full reload completes correctly.
- Backpressure stress: in_valid toggled randomly during a load:
  - No word is lost or duplicated; cfg_shift is never high while bits_left==0.
  - in_ready is only high in LOAD.
- rst asserted mid-word (3rd bit of word 4):
  - All outputs 0 asynchronously; IDLE after release.
  - start-less in_valid is ignored; a new load completes normally.
- start pulsed during LOAD, and abort pulsed in IDLE:
  - Neither changes state or counters; err is unchanged.
